mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between an initiator and the iterative multiply/divide unit.
// Handshake: start is the valid, !busy is the ready; an op is accepted on a rising edge with start && !busy.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply (shift-add) / restoring divide unit with a 2*WIDTH result.
// Signed ops run the unsigned loop on magnitudes; signs are fixed up on entry to DONE.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_div_unit_if.slave     bus,
  output logic [1:0]        state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   low;
  logic [WIDTH-1:0]   opd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               dbz;
  logic               busy_c;
  logic               done_c;

  logic               sign_a, sign_b, div_zero, accept, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     acc_n, mul_sum, div_shift;
  logic [WIDTH-1:0]   low_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    sign_a    = bus.op[0] & bus.a[WIDTH-1];
    sign_b    = bus.op[0] & bus.b[WIDTH-1];
    mag_a     = sign_a ? (~bus.a + 1'b1) : bus.a;
    mag_b     = sign_b ? (~bus.b + 1'b1) : bus.b;
    div_zero  = bus.op[1] && (bus.b == '0);
    accept    = (state == IDLE) && bus.start;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // One loop step. Multiply keeps the partial product in acc with the multiplier
  // shifting out of low; divide shifts the dividend out of low into the remainder.
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    acc_n     = acc;
    low_n     = low;
    if (is_div) begin
      div_shift = {acc[WIDTH-1:0], low[WIDTH-1]};
      if (div_shift >= {1'b0, opd}) begin
        acc_n = div_shift - {1'b0, opd};
        low_n = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = div_shift;
        low_n = {low[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum = low[0] ? (acc + {1'b0, opd}) : acc;
      acc_n   = {1'b0, mul_sum[WIDTH:1]};
      low_n   = {mul_sum[0], low[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {acc_n[WIDTH-1:0], low_n};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quot_fix = neg_q ? (~low_n + 1'b1) : low_n;
    rem_fix  = neg_r ? (~acc_n[WIDTH-1:0] + 1'b1) : acc_n[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = div_zero ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      low    <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      dbz    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      is_div <= bus.op[1];
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      dbz    <= div_zero;
      if (bus.op[1]) begin
        low <= mag_a;
        opd <= mag_b;
      end else begin
        low <= mag_b;
        opd <= mag_a;
      end
      // Divide by zero skips the loop: all-ones quotient, untouched dividend as remainder.
      if (div_zero) begin
        res_lo <= '1;
        res_hi <= bus.a;
      end
    end else if (state == CALC) begin
      acc <= acc_n;
      low <= low_n;
      if (last_iter) begin
        if (is_div) begin
          res_lo <= quot_fix;
          res_hi <= rem_fix;
        end else begin
          res_lo <= prod_fix[WIDTH-1:0];
          res_hi <= prod_fix[2*WIDTH-1:WIDTH];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.result_lo   = res_lo;
  assign bus.result_hi   = res_hi;
  assign bus.div_by_zero = dbz;
  assign state_dbg       = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products/quotients, latency,
// ignored starts, divide-by-zero and asynchronous reset mid-operation.
module tb_mul_div_unit;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         vectors = 0;
  int         errors = 0;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives an op, follows it to done, then checks the following IDLE cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz, input int inject_cyc);
    int cyc;
    bit busy_ok;
    bit seen;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    cyc     = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == 1 && exp_lat != 1) check({tag, " dbz_cleared"}, 64'(bus.div_by_zero), 64'd0);
      if (inject_cyc != 0 && cyc == inject_cyc) begin
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else if (inject_cyc != 0 && cyc == inject_cyc + 1) begin
        bus.start = 1'b0;
        bus.a     = a;
        bus.b     = b;
      end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, " result"}, {bus.result_hi, bus.result_lo}, {exp_hi, exp_lo});
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    @(negedge clk);
    check({tag, " done_one_cycle"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, " result_hold"}, {bus.result_hi, bus.result_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_done;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    #1;
    check("reset outputs", {29'd0, bus.busy, bus.done, bus.div_by_zero, bus.result_hi},
          64'd0);
    check("reset result_lo", 64'(bus.result_lo), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mulu 7*6",      2'b00, 32'd7,          32'd6,          33, 32'h0000_0000, 32'h0000_002A, 1'b0, 0);
    run_op("mulu max*max",  2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mul -3*5",      2'b01, 32'hFFFF_FFFD,  32'd5,          33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run_op("mul -3*-5",     2'b01, 32'hFFFF_FFFD,  32'hFFFF_FFFB,  33, 32'h0000_0000, 32'h0000_000F, 1'b0, 0);
    run_op("divu 100/7",    2'b10, 32'd100,        32'd7,          33, 32'd2,         32'd14,        1'b0, 0);
    run_op("divu 5/9",      2'b10, 32'd5,          32'd9,          33, 32'd5,         32'd0,         1'b0, 0);
    run_op("div -7/2",      2'b11, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div 7/-2",      2'b11, 32'd7,          32'hFFFF_FFFE,  33, 32'd1,         32'hFFFF_FFFD, 1'b0, 0);
    run_op("div overflow",  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,         32'h8000_0000, 1'b0, 0);
    run_op("divu by zero",  2'b10, 32'h0000_1234,  32'd0,          1,  32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div by zero",   2'b11, 32'hFFFF_FFFB,  32'd0,          1,  32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("mulu after dz", 2'b00, 32'd3,          32'd4,          33, 32'd0,         32'd12,        1'b0, 0);
    run_op("mulu ignore",   2'b00, 32'd7,          32'd6,          33, 32'd0,         32'd42,        1'b0, 10);

    // Async reset between edges during cycle 15 of a divide.
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    check("async reset result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("async reset state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) any_done = 1'b1;
    end
    check("no done after reset", 64'(any_done), 64'd0);

    run_op("divu after rst", 2'b10, 32'd1000, 32'd3, 33, 32'd1, 32'd333, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
